// File: rtl/apb_bus_arbiter.sv
// rtl/apb_bus_arbiter.sv - two-requester round-robin APB master with wait-state timeout
module apb_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              req0_i,
  input  logic              write0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              write1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              err0_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              ack1_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q;
  logic              last_q;
  logic              owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic elig0, elig1, grant;

  // A requester being acknowledged this cycle still has its old REQ high.
  assign elig0 = req0_i & ~ack0_q;
  assign elig1 = req1_i & ~ack1_q;
  assign grant = (elig0 & elig1) ? ~last_q : elig1;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (elig0 | elig1) begin
            state_q  <= SETUP;
            owner_q  <= grant;
            last_q   <= grant;
            pwrite_q <= grant ? write1_i : write0_i;
            paddr_q  <= grant ? addr1_i  : addr0_i;
            pwdata_q <= grant ? wdata1_i : wdata0_i;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= '0;
        end
        ACCESS: begin
          if (pready_i) begin
            state_q <= IDLE;
            if (!pwrite_q) begin
              if (owner_q) rdata1_q <= prdata_i;
              else         rdata0_q <= prdata_i;
            end
            if (owner_q) ack1_q <= 1'b1;
            else         ack0_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            if (owner_q) begin
              ack1_q <= 1'b1;
              err1_q <= 1'b1;
            end else begin
              ack0_q <= 1'b1;
              err0_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign err0_o    = err0_q;
  assign err1_o    = err1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb/tb_apb_bus_arbiter.sv - self-checking bench for apb_bus_arbiter with register-file slave stub
module tb_apb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, write0, req1, write1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] smem  [4];
  logic [31:0] mem_m [4];
  logic [31:0] rd_m  [2];
  int          wait_n = 0;
  bit          stuck  = 1'b0;
  int          wcnt   = 0;

  always #5 clk = ~clk;

  apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk_i(clk), .preset_n_i(rst_n),
    .req0_i(req0), .write0_i(write0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .write1_i(write1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack0_o(ack0), .err0_o(err0), .rdata0_o(rdata0),
    .ack1_o(ack1), .err1_o(err1), .rdata1_o(rdata1),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
  );

  assign pready = psel & penable & ~stuck & (wcnt >= wait_n);
  assign prdata = smem[paddr[3:2]];

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready && pwrite) smem[paddr[3:2]] <= pwdata;
  end

  task automatic do_xfer(input int who, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input string tag);
    int lat = 0;
    bit got = 1'b0;
    wait_n = waits;
    if (who == 0) begin req0 = 1'b1; write0 = wr; addr0 = a; wdata0 = wd; end
    else          begin req1 = 1'b1; write1 = wr; addr1 = a; wdata1 = wd; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, wr, a}) begin
          $display("FAIL %s setup: got psel/pen/pwrite/paddr=%b%b%b/%h want 10%b/%h",
                   tag, psel, penable, pwrite, paddr, wr, a);
          n_fail++;
        end
        n_checks++;
        if (wr && pwdata !== wd) begin
          $display("FAIL %s pwdata: got %h want %h", tag, pwdata, wd);
          n_fail++;
        end
        if (wr) n_checks++;
      end
      if (lat == 2) begin
        if ({psel, penable} !== 2'b11) begin
          $display("FAIL %s access: got psel/pen=%b%b want 11", tag, psel, penable);
          n_fail++;
        end
        n_checks++;
      end
      if (ack0 || ack1) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL %s no_ack: no ACK within 40 cycles", tag);
      n_fail++;
    end else begin
      if (lat !== 3 + waits) begin
        $display("FAIL %s latency: got %0d want %0d", tag, lat, 3 + waits);
        n_fail++;
      end
      n_checks++;
      if ({ack1, ack0, err1, err0} !== ((who == 1) ? 4'b1000 : 4'b0100)) begin
        $display("FAIL %s ack_err: got ack1/ack0/err1/err0=%b%b%b%b", tag, ack1, ack0, err1, err0);
        n_fail++;
      end
      n_checks++;
      if (wr) mem_m[a[3:2]] = wd;
      else    rd_m[who]     = mem_m[a[3:2]];
      if (rdata0 !== rd_m[0] || rdata1 !== rd_m[1]) begin
        $display("FAIL %s rdata: got %h/%h want %h/%h", tag, rdata0, rdata1, rd_m[0], rd_m[1]);
        n_fail++;
      end
      n_checks++;
    end
    if (who == 0) req0 = 1'b0;
    else          req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hdead;
    @(negedge clk);
    @(negedge clk);
    if ({psel, penable, pwrite, ack0, ack1, err0, err1} !== 7'b0 ||
        {paddr, pwdata, rdata0, rdata1} !== 128'b0) begin
      $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h rdata=%h/%h",
               psel, penable, paddr, pwdata, rdata0, rdata1);
      n_fail++;
    end
    n_checks++;
    req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    if (psel !== 1'b0) begin
      $display("FAIL reset_idle: got psel=%b want 0", psel);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_write_zero_wait;
    do_xfer(0, 1'b1, 32'h0, 32'h3139, 0, "write0");
    if (smem[0] !== 32'h3139) begin
      $display("FAIL write0_slave: got %h want 00003139", smem[0]);
      n_fail++;
    end
    n_checks++;
    do_xfer(1, 1'b0, 32'h0, 32'h0, 0, "readback1");
  endtask

  task automatic test_read_with_waits;
    do_xfer(0, 1'b1, 32'h4, 32'h32313132, 0, "preload");
    do_xfer(1, 1'b0, 32'h4, 32'h0, 2, "read1_wait2");
    if (rdata1 !== 32'h32313132) begin
      $display("FAIL read1_value: got %h want 32313132", rdata1);
      n_fail++;
    end
    n_checks++;
    do_xfer(0, 1'b0, 32'h0, 32'h0, 1, "read0_wait1");
  endtask

  task automatic test_timeout;
    int acc = 0;
    bit got = 1'b0;
    stuck = 1'b1;
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'hC;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (psel && penable) acc++;
      if (ack0 || ack1) got = 1'b1;
    end
    if (!got || acc !== 16) begin
      $display("FAIL timeout_len: ack=%b access_cycles=%0d want 16", got, acc);
      n_fail++;
    end
    n_checks++;
    if ({ack0, err0, ack1, err1} !== 4'b1100) begin
      $display("FAIL timeout_pulse: got ack0/err0/ack1/err1=%b%b%b%b want 1100", ack0, err0, ack1, err1);
      n_fail++;
    end
    n_checks++;
    if (rdata0 !== rd_m[0]) begin
      $display("FAIL timeout_rdata: got %h want %h", rdata0, rd_m[0]);
      n_fail++;
    end
    n_checks++;
    req0 = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    if ({psel, ack0, err0} !== 3'b000) begin
      $display("FAIL timeout_after: got psel/ack0/err0=%b%b%b want 000", psel, ack0, err0);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      do_xfer(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              32'($urandom_range(3, 0)) << 2, $urandom, int'($urandom_range(3, 0)), "random");
    end
  endtask

  task automatic test_contention;
    int          order[$];
    int          acyc[$];
    logic [31:0] pa[$];
    int          cyc = 0;
    logic [31:0] d0, d1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wait_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_m[0] = '0; rd_m[1] = '0;
    d0 = $urandom; d1 = $urandom;
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'h8; wdata0 = d0;
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'hC; wdata1 = d1;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk);
      cyc++;
      if (psel && penable) pa.push_back(paddr);
      if (ack0) begin
        order.push_back(0); acyc.push_back(cyc);
        mem_m[2] = d0; d0 = $urandom; wdata0 = d0;
      end
      if (ack1) begin
        order.push_back(1); acyc.push_back(cyc);
        mem_m[3] = d1; d1 = $urandom; wdata1 = d1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    if (order.size() !== 4 || pa.size() !== 4) begin
      $display("FAIL cont_count: acks=%0d accesses=%0d want 4/4", order.size(), pa.size());
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < order.size() && i < pa.size(); i++) begin
      if (order[i] !== (i % 2) || pa[i] !== ((i % 2 == 1) ? 32'hC : 32'h8) ||
          acyc[i] !== 3 * (i + 1)) begin
        $display("FAIL cont_grant%0d: got req%0d paddr=%h cycle=%0d want req%0d cycle=%0d",
                 i, order[i], pa[i], acyc[i], i % 2, 3 * (i + 1));
        n_fail++;
      end
      n_checks++;
    end
    @(negedge clk);
    if (psel !== 1'b0 || smem[2] !== mem_m[2] || smem[3] !== mem_m[3]) begin
      $display("FAIL cont_final: psel=%b mem8=%h/%h memC=%h/%h", psel, smem[2], mem_m[2], smem[3], mem_m[3]);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid;
    bit          found = 1'b0;
    int          lat = 0;
    int          order[$];
    int          acyc[$];
    logic [31:0] d;
    d = $urandom;
    stuck = 1'b1;
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'h4; wdata1 = d;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (psel && penable) found = 1'b1;
    end
    if (!found) begin
      $display("FAIL rmid_access: ACCESS never reached");
      n_fail++;
    end
    n_checks++;
    #2 rst_n = 1'b0;
    #1;
    if ({psel, penable, pwrite, ack0, ack1, err0, err1} !== 7'b0 ||
        {paddr, pwdata, rdata0, rdata1} !== 128'b0) begin
      $display("FAIL rmid_async: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rdata=%h/%h",
               psel, penable, pwrite, paddr, pwdata, rdata0, rdata1);
      n_fail++;
    end
    n_checks++;
    rd_m[0] = '0; rd_m[1] = '0;
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h8;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if ({ack1, psel} !== 2'b00) begin
        $display("FAIL rmid_held: got ack1/psel=%b%b want 00", ack1, psel);
        n_fail++;
      end
      n_checks++;
    end
    stuck = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 20 && order.size() < 2; k++) begin
      @(negedge clk);
      lat++;
      if (ack0) begin order.push_back(0); acyc.push_back(lat); req0 = 1'b0; rd_m[0] = mem_m[2]; end
      if (ack1) begin order.push_back(1); acyc.push_back(lat); req1 = 1'b0; mem_m[1] = d; end
    end
    if (order.size() !== 2) begin
      $display("FAIL rmid_acks: got %0d acks want 2", order.size());
      n_fail++;
    end else if (order[0] !== 0 || acyc[0] !== 3 || order[1] !== 1 || acyc[1] !== 6) begin
      $display("FAIL rmid_order: got req%0d@%0d req%0d@%0d want req0@3 req1@6",
               order[0], acyc[0], order[1], acyc[1]);
      n_fail++;
    end
    n_checks++;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    if (rdata0 !== rd_m[0] || smem[1] !== mem_m[1]) begin
      $display("FAIL rmid_data: rdata0=%h want %h mem4=%h want %h", rdata0, rd_m[0], smem[1], mem_m[1]);
      n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin smem[i] = '0; mem_m[i] = '0; end
    rd_m[0] = '0; rd_m[1] = '0;
    req0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_zero_wait();
    test_read_with_waits();
    test_timeout();
    test_random();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Two-requester APB bus controller that shares one APB slave port (the register-file slave at 0x0/0x4/0x8/0xC) between two independent requesters. It arbitrates round-robin, runs the APB SETUP/ACCESS sequence itself, captures read data, and aborts transfers whose PREADY never arrives. It sits between the requesters and the APB slave, in place of a single-owner master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles before abort (≥2)
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  transfer request, held high with stable command until ACKn
- WRITE0 / WRITE1  in  1  1 = write, 0 = read
- ADDR0 / ADDR1  in  ADDR_W  register address
- WDATA0 / WDATA1  in  DATA_W  write data
- ACK0 / ACK1  out  1  one-cycle completion pulse
- ERR0 / ERR1  out  1  one-cycle pulse with ACKn on timeout abort
- RDATA0 / RDATA1  out  DATA_W  read result, valid from ACKn, held until next successful read for that requester
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

## Operation
- States: IDLE, SETUP, ACCESS. IDLE: PSEL=0, PENABLE=0. SETUP: PSEL=1, PENABLE=0. ACCESS: PSEL=1, PENABLE=1.
- IDLE → SETUP when any eligible REQn is high. A requester whose ACKn is high in the current cycle is not eligible.
- Arbitration is round-robin. Register `last` resets to 1, so requester 0 wins the first contention. With both eligible, the grant goes to the one ≠ `last`; with one eligible, that one wins. `last` updates on the IDLE→SETUP edge.
- On IDLE→SETUP, the granted requester's WRITE/ADDR/WDATA are latched into PWRITE/PADDR/PWDATA. These stay stable through SETUP and ACCESS and hold their values in IDLE.
- SETUP → ACCESS unconditionally.
- ACCESS with PREADY=1:
  - On a read, PRDATA is captured into RDATAn.
  - ACKn is pulsed and the state goes to IDLE.
- ACCESS with PREADY=0: the wait counter increments and the state stays in ACCESS.
- Timeout: if PREADY=0 at the edge where counter = TIMEOUT−1:
  - ACKn and ERRn are pulsed together and the state goes to IDLE.
  - RDATAn is unchanged.
- The counter clears on SETUP→ACCESS.
- REQ of the non-granted requester may change freely during a transfer. The granted requester's inputs are not sampled after the grant.
- Reset (PRESET=0, async): state=IDLE, `last`=1, counter=0, and all outputs 0. This includes RDATAn, PADDR, PWDATA and PWRITE. A transfer in progress is dropped with no ACK.

## Timing
- Requests are sampled at edge E in IDLE. SETUP is cycle E+1, ACCESS is E+2, and ACKn is high in cycle E+3 (zero wait states).
- Each PREADY=0 cycle adds one cycle of latency.
- ACKn/ERRn are registered one-cycle pulses, high in the IDLE cycle after the final ACCESS edge.
- Back-to-back throughput: one transfer per 3 cycles. The ACK cycle is always an IDLE cycle, and the next SETUP can start in the cycle after it.
- A requester must drop REQn, or present a new command, in the cycle after ACKn. REQn still high then is a new request.
- On timeout, ACCESS lasts exactly TIMEOUT cycles.

## Test plan
- Write, zero wait:
  - Stimulus: REQ0 with WRITE0=1, ADDR0=0x0, WDATA0=0x3139.
  - Required: PSEL with PENABLE=0 for 1 cycle, then PSEL and PENABLE for 1 cycle, with PADDR=0x0 and PWDATA=0x3139.
  - Required: ACK0 3 cycles after the request is sampled, ERR0=0, and the slave register reads back 0x3139.
- Read with waits:
  - Stimulus: REQ1 read of 0x4; slave holds PREADY=0 for 2 ACCESS cycles, then returns 0x32313132.
  - Required: ACK1 at request+5 cycles, with RDATA1=0x32313132 and RDATA0 unchanged.
- Contention:
  - Stimulus: REQ0 and REQ1 asserted in the same cycle after reset and held continuously, ADDR0=0x8, ADDR1=0xC.
  - Required: grant order 0,1,0,1; PADDR alternates 0x8/0xC; ACKs are 3 cycles apart.
  - Required: no requester issues twice per ACK, which checks the ACK-cycle mask.
- Timeout:
  - Stimulus: TIMEOUT=16; REQ0 read of 0xC; slave ties PREADY=0.
  - Required: ACCESS lasts 16 cycles, then ACK0 and ERR0 pulse together, RDATA0 is unchanged, and PSEL=0 next cycle.
- Reset mid-transfer:
  - Stimulus: PRESET low during ACCESS of a REQ1 write.
  - Required: PSEL, PENABLE and all outputs go to 0 immediately without a clock edge, and no ACK1.
  - Required: after release, a pending REQ0 and REQ1 → REQ0 granted first.
